// File: rtl/hex_report_pkg.sv
// Shared constants, FSM state type and digit-count helper for the
// measurement report serializer.
package hex_report_pkg;

    localparam logic [7:0] COMMA = 8'h2C;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEQ_DIG,
        ST_SEQ_SEP,
        ST_CH_DIG,
        ST_CH_SEP,
        ST_FREQ_DIG,
        ST_CR,
        ST_LF
    } state_t;

    // Number of hex digits needed for a w-bit word.
    function automatic int hex_digits(input int w);
        return (w + 3) / 4;
    endfunction

endpackage

// File: rtl/hex_nib2ascii.sv
// Combinational 4-bit nibble to uppercase ASCII hex digit.
module hex_nib2ascii (
    input  logic [3:0] nib,
    output logic [7:0] ascii
);

    // 0-9 -> '0'..'9', A-F -> 'A'..'F'
    always_comb begin
        if (nib < 4'd10) begin
            ascii = 8'h30 + {4'h0, nib};
        end else begin
            ascii = 8'h37 + {4'h0, nib};
        end
    end

endmodule

// File: rtl/hex_report_tx.sv
// Report frame serializer: snapshots NUM_CH phase words plus one frequency
// word on a start strobe and streams them as one ASCII hex line over a
// valid/ready byte interface, with sequence numbering and overrun counting.
module hex_report_tx
    import hex_report_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 30,
    parameter int FREQ_W = 28,
    parameter int SEQ_EN = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH*CH_W-1:0]   i_ph,
    input  logic [FREQ_W-1:0]        i_freq,
    input  logic                     i_start,
    output logic [7:0]               o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_busy,
    output logic                     o_overrun,
    output logic [7:0]               o_drop_cnt
);

    localparam int D_CH    = hex_digits(CH_W);
    localparam int D_F     = hex_digits(FREQ_W);
    localparam int CHW4    = 4 * D_CH;
    localparam int FW4     = 4 * D_F;
    localparam int PH_BITS = NUM_CH * CHW4;

    localparam logic [3:0] NIB_CH_TOP = 4'(D_CH - 1);
    localparam logic [3:0] NIB_F_TOP  = 4'(D_F - 1);
    localparam logic [3:0] CH_LAST    = 4'(NUM_CH - 1);
    localparam state_t     FIRST_ST   = (SEQ_EN != 0) ? ST_SEQ_DIG : ST_CH_DIG;
    localparam logic [3:0] FIRST_NIB  = (SEQ_EN != 0) ? 4'd1 : NIB_CH_TOP;

    state_t               state, state_nx;
    logic [3:0]           nib_idx, nib_nx;
    logic [3:0]           ch_idx, ch_nx;
    logic [7:0]           seq, seq_snap, drop_cnt;
    logic [PH_BITS-1:0]   ph_ext, ph_snap;
    logic [FW4-1:0]       freq_ext, freq_snap;
    logic                 overrun;
    logic                 hs, lf_hs, accept, drop;
    logic [3:0]           nib;
    logic [7:0]           nib_ascii;

    assign hs     = (state != ST_IDLE) && i_ready;
    assign lf_hs  = (state == ST_LF) && i_ready;
    assign accept = i_start && ((state == ST_IDLE) || lf_hs);
    assign drop   = i_start && !accept;

    // Zero-extend every incoming word to a whole number of nibbles
    always_comb begin
        ph_ext = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ph_ext[k*CHW4 +: CH_W] = i_ph[k*CH_W +: CH_W];
        end
        freq_ext = '0;
        freq_ext[FREQ_W-1:0] = i_freq;
    end

    // Next-state and digit/channel counter sequencing, advancing on handshakes
    always_comb begin
        state_nx = state;
        nib_nx   = nib_idx;
        ch_nx    = ch_idx;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = FIRST_ST;
                    nib_nx   = FIRST_NIB;
                    ch_nx    = 4'd0;
                end
            end
            ST_SEQ_DIG: begin
                if (hs) begin
                    if (nib_idx == 4'd0) state_nx = ST_SEQ_SEP;
                    else                 nib_nx   = nib_idx - 4'd1;
                end
            end
            ST_SEQ_SEP: begin
                if (hs) begin
                    state_nx = ST_CH_DIG;
                    nib_nx   = NIB_CH_TOP;
                    ch_nx    = 4'd0;
                end
            end
            ST_CH_DIG: begin
                if (hs) begin
                    if (nib_idx == 4'd0) state_nx = ST_CH_SEP;
                    else                 nib_nx   = nib_idx - 4'd1;
                end
            end
            ST_CH_SEP: begin
                if (hs) begin
                    if (ch_idx == CH_LAST) begin
                        state_nx = ST_FREQ_DIG;
                        nib_nx   = NIB_F_TOP;
                    end else begin
                        state_nx = ST_CH_DIG;
                        nib_nx   = NIB_CH_TOP;
                        ch_nx    = ch_idx + 4'd1;
                    end
                end
            end
            ST_FREQ_DIG: begin
                if (hs) begin
                    if (nib_idx == 4'd0) state_nx = ST_CR;
                    else                 nib_nx   = nib_idx - 4'd1;
                end
            end
            ST_CR: begin
                if (hs) state_nx = ST_LF;
            end
            ST_LF: begin
                if (hs) begin
                    if (accept) begin
                        state_nx = FIRST_ST;
                        nib_nx   = FIRST_NIB;
                        ch_nx    = 4'd0;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Control state, sequence counter, snapshots and drop accounting
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            nib_idx   <= 4'd0;
            ch_idx    <= 4'd0;
            seq       <= 8'h00;
            seq_snap  <= 8'h00;
            ph_snap   <= '0;
            freq_snap <= '0;
            drop_cnt  <= 8'h00;
            overrun   <= 1'b0;
        end else begin
            state   <= state_nx;
            nib_idx <= nib_nx;
            ch_idx  <= ch_nx;
            overrun <= drop;
            if (lf_hs) begin
                seq <= seq + 8'd1;
            end
            // A start taken on the LF handshake belongs to the next sequence number
            if (accept) begin
                ph_snap   <= ph_ext;
                freq_snap <= freq_ext;
                seq_snap  <= lf_hs ? seq + 8'd1 : seq;
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Pick the current nibble by shifting the selected snapshot word down
    always_comb begin
        nib = 4'h0;
        case (state)
            ST_SEQ_DIG:  nib = 4'(seq_snap >> (int'(nib_idx) * 4));
            ST_CH_DIG:   nib = 4'(ph_snap >> (int'(ch_idx) * CHW4 + int'(nib_idx) * 4));
            ST_FREQ_DIG: nib = 4'(freq_snap >> (int'(nib_idx) * 4));
            default:     nib = 4'h0;
        endcase
    end

    hex_nib2ascii u_nib2ascii (
        .nib   (nib),
        .ascii (nib_ascii)
    );

    // Output byte for the current state; idle shows 0x00
    always_comb begin
        case (state)
            ST_SEQ_DIG, ST_CH_DIG, ST_FREQ_DIG: o_data = nib_ascii;
            ST_SEQ_SEP, ST_CH_SEP:              o_data = COMMA;
            ST_CR:                              o_data = CR;
            ST_LF:                              o_data = LF;
            default:                            o_data = 8'h00;
        endcase
    end

    assign o_valid    = (state != ST_IDLE);
    assign o_busy     = (state != ST_IDLE);
    assign o_overrun  = overrun;
    assign o_drop_cnt = drop_cnt;

endmodule
